// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: fetch FSM states,
// opcode constants used by the control decoder, and the default reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump beats branch beats sequential. Purely combinational
// so it can be dropped into a pipelined fetch stage unchanged.
module next_pc_sel (
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_i,
    input  logic [31:0] branch_off_i,
    input  logic        jump_i,
    input  logic [25:0] jump_idx_i,
    output logic [31:0] next_pc_o
);

    // Priority select; branch offset is in words, addition wraps mod 2^32.
    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = {pc_plus4_i[31:28], jump_idx_i, 2'b00};
        end else if (branch_i) begin
            next_pc_o = pc_plus4_i + {branch_off_i[29:0], 2'b00};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word over a req/ack
// handshake, holds it for decode until retire, then advances the PC.
//
// Handshake: imem_req_o is raised with a stable imem_addr_o and stays high
// until a cycle with imem_ack_i=1, at which edge imem_data_i is captured;
// ack may coincide with the first cycle of req. The instruction is then
// presented with inst_valid_o=1 until a cycle with retire_i=1, which consumes
// it. ack outside FETCH and retire outside VALID have no effect.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_ack_i,
    input  logic [31:0]  imem_data_i,
    output logic         inst_valid_o,
    output logic [31:0]  inst_o,
    output logic [5:0]   op_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  pc_plus4_o,
    input  logic         retire_i,
    input  logic         branch_i,
    input  logic [31:0]  branch_off_i,
    input  logic         jump_i,
    input  logic [25:0]  jump_idx_i,
    output fetch_state_e dbg_state_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4_i   (pc_plus4),
        .branch_i     (branch_i),
        .branch_off_i (branch_off_i),
        .jump_i       (jump_i),
        .jump_idx_i   (jump_idx_i),
        .next_pc_o    (next_pc)
    );

    // State register; reset drops req immediately, discarding any response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; req/valid are computed one cycle ahead so the
    // outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        req_d   = req_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (imem_ack_i) begin
                    inst_d  = imem_data_i;
                    state_d = VALID;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            VALID: begin
                if (retire_i) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign op_o         = inst_q[31:26];
    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_plus4;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed instructions from the test plan followed by
// randomized fetch/retire traffic, checked against an architectural PC model.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_data;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [5:0]   op;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         retire;
  logic         branch;
  logic [31:0]  branch_off;
  logic         jump;
  logic [25:0]  jump_idx;
  fetch_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_data_i  (imem_data),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .op_o         (op),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .retire_i     (retire),
    .branch_i     (branch),
    .branch_off_i (branch_off),
    .jump_i       (jump),
    .jump_idx_i   (jump_idx),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // architectural next-PC rule
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic br,
                                           input logic [31:0] off, input logic jmp,
                                           input logic [25:0] idx);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    if (br)  return seq + off * 32'd4;
    return seq;
  endfunction

  // branch offset (in words) that takes cur to target
  function automatic logic [31:0] off_to(input logic [31:0] cur, input logic [31:0] target);
    return (target - cur - 32'd4) >> 2;
  endfunction

  // One full instruction: called just after a negedge with the DUT in FETCH.
  task automatic do_instr(input int waits, input logic [31:0] data, input logic br,
                          input logic [31:0] off, input logic jmp, input logic [25:0] idx);
    int hold;
    check_eq("req_fetch", {31'd0, imem_req}, 32'd1);
    check_eq("addr_fetch", imem_addr, exp_pc);
    check_eq("pc_fetch", pc, exp_pc);
    check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
    check_eq("valid_fetch", {31'd0, inst_valid}, 32'd0);
    exp_q.push_back(data);
    for (int w = 0; w < waits; w++) begin
      imem_ack  = 1'b0;
      imem_data = $urandom;
      retire    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("req_wait", {31'd0, imem_req}, 32'd1);
      check_eq("addr_wait", imem_addr, exp_pc);
      check_eq("valid_wait", {31'd0, inst_valid}, 32'd0);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    retire    = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("valid_ack", {31'd0, inst_valid}, 32'd1);
    check_eq("inst_ack", inst, exp_q[0]);
    check_eq("op_ack", {26'd0, op}, {26'd0, exp_q[0][31:26]});
    check_eq("req_valid", {31'd0, imem_req}, 32'd0);
    check_eq("pc_valid", pc, exp_pc);
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_data  = $urandom;
      retire     = 1'b0;
      branch     = 1'($urandom_range(0, 1));
      jump       = 1'($urandom_range(0, 1));
      branch_off = $urandom;
      jump_idx   = 26'($urandom);
      @(negedge clk);
      check_eq("inst_hold", inst, exp_q[0]);
      check_eq("valid_hold", {31'd0, inst_valid}, 32'd1);
      check_eq("pc_hold", pc, exp_pc);
    end
    imem_ack   = 1'($urandom_range(0, 1));
    imem_data  = $urandom;
    retire     = 1'b1;
    branch     = br;
    branch_off = off;
    jump       = jmp;
    jump_idx   = idx;
    exp_pc     = ref_next(exp_pc, br, off, jmp, idx);
    void'(exp_q.pop_front());
    @(negedge clk);
    imem_ack = 1'b0;
    retire   = 1'b0;
    check_eq("valid_drop", {31'd0, inst_valid}, 32'd0);
    check_eq("pc_next", pc, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 32'h0; retire = 1'b0;
    branch = 1'b0; branch_off = 32'h0; jump = 1'b0; jump_idx = 26'h0;
    exp_pc = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc4", pc_plus4, 32'h4);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_op", {26'd0, op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("state_c1", {30'd0, dbg_state}, {30'd0, FETCH});

    // addi at 0, zero-wait memory
    do_instr(0, 32'h2008_0005, 1'b0, 32'h0, 1'b0, 26'h0);
    // 3 wait states, branch to 0x10
    do_instr(3, $urandom, 1'b1, off_to(exp_pc, 32'h10), 1'b0, 26'h0);
    // backward branch from 0x10 to 0x0C
    do_instr(1, $urandom, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    check_eq("bwd_branch", exp_pc, 32'h0000_000C);
    do_instr(0, $urandom, 1'b1, off_to(exp_pc, 32'h4000_0000), 1'b0, 26'h0);
    // jump overrides branch
    do_instr(2, $urandom, 1'b1, 32'h0000_0100, 1'b1, 26'h000_0040);
    check_eq("jump_pri_pc", pc, 32'h4000_0100);
    do_instr(0, $urandom, 1'b1, off_to(exp_pc, 32'hFFFF_FFFC), 1'b0, 26'h0);
    // sequential wrap
    do_instr(1, {OP_BEQ, 26'h0}, 1'b0, 32'h0, 1'b0, 26'h0);
    check_eq("wrap_pc", pc, 32'h0);

    for (int i = 0; i < 40; i++) begin
      do_instr($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 3) == 0), 26'($urandom));
    end

    // reset mid-fetch with a late ack
    imem_ack = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_async_pc", pc, 32'h0);
    exp_pc = 32'h0;
    @(negedge clk);
    rst_n     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("idle_ack_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("idle_ack_inst", inst, 32'h0);
    do_instr(0, {OP_LW, 26'h123}, 1'b0, 32'h0, 1'b0, 26'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
